mem_responder: RTL and testbench

Handshaked, single-outstanding-request memory responder: a word-organised RAM behind a valid/ready request channel and a valid/ready response channel, with configurable fixed access latency and byte-enabled writes. It is the memory end of the processor's data port once the core moves from the zero-latency combinational memory to a multi-cycle load/store path. It serves both loads and stores, reports misaligned accesses, and applies backpressure while a transaction is in flight.

---
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_responder.sv | 118 +++++++++++
 tb/tb_mem_responder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between a load/store master and the memory responder.
// The master drives the request fields and rsp_ready.
// The responder drives req_ready and the response fields.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding memory responder.
// It holds a word-organised RAM with byte-enabled stores and a fixed access
// latency. Misaligned accesses are flagged and never touch memory.
module mem_responder #(
  parameter int ADDR_W  = 13,
  parameter int LATENCY = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] idx_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              mis_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // The access happens on the edge that enters RESP. With LATENCY = 1 that
  // edge is the acceptance edge, so the access fields come straight from the
  // bus. Otherwise they come from the copy latched at acceptance.
  logic              access;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_we;
  logic [3:0]        acc_be;
  logic [31:0]       acc_wdata;
  logic              acc_mis;
  logic              wr_en;
  logic              unused_addr_hi;

  // Upper address bits above the word index are ignored, so the index wraps.
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  // Select the access source and decide whether this edge performs it.
  always_comb begin
    access    = 1'b0;
    acc_idx   = idx_q;
    acc_we    = we_q;
    acc_be    = be_q;
    acc_wdata = wdata_q;
    acc_mis   = mis_q;
    if (state_q == IDLE) begin
      access    = bus.req_valid && (LATENCY == 1);
      acc_idx   = bus.req_addr[ADDR_W+1:2];
      acc_we    = bus.req_we;
      acc_be    = bus.req_be;
      acc_wdata = bus.req_wdata;
      acc_mis   = (bus.req_addr[1:0] != 2'b00);
    end else if (state_q == WAIT) begin
      access = (cnt_q <= 4'd1);
    end
  end

  // A store pending while reset is asserted is discarded.
  assign wr_en = access && acc_we && !acc_mis && !rst_i;

  // Byte-lane RAM write. This block has no reset, so memory survives reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  // Control FSM: accept, count down the latency, then hold the response
  // until it is taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            idx_q   <= bus.req_addr[ADDR_W+1:2];
            we_q    <= bus.req_we;
            be_q    <= bus.req_be;
            wdata_q <= bus.req_wdata;
            mis_q   <= (bus.req_addr[1:0] != 2'b00);
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q <= 4'd1) begin
            cnt_q   <= 4'd0;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (access) begin
        rdata_q <= (!acc_we && !acc_mis) ? mem[acc_idx] : 32'd0;
        err_q   <= acc_mis;
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder.
// Three instances run with LATENCY 1, 2 and 4. A scoreboard queue holds the
// expected responses, and a word model of each memory tracks stored data.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_accept = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]        rv, rwe, rr;
  logic [2:0][31:0]  ra, rwd;
  logic [2:0][3:0]   rbe;
  logic [2:0]        qready, svalid, serr;
  logic [2:0][31:0]  srdata;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mem_responder_if bus ();
    assign bus.req_valid = rv[gi];
    assign bus.req_addr  = ra[gi];
    assign bus.req_we    = rwe[gi];
    assign bus.req_be    = rbe[gi];
    assign bus.req_wdata = rwd[gi];
    assign bus.rsp_ready = rr[gi];
    assign qready[gi]    = bus.req_ready;
    assign svalid[gi]    = bus.rsp_valid;
    assign srdata[gi]    = bus.rsp_rdata;
    assign serr[gi]      = bus.rsp_err;
    mem_responder #(.ADDR_W(13), .LATENCY(gi == 0 ? 1 : (gi == 1 ? 2 : 4))) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
    );
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];
  logic [31:0] model [3][8192];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction: drive the request, measure the latency, hold
  // the response for 'hold' cycles (optionally with a competing request),
  // then perform the handshake.
  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wdata,
                     input int hold, input logic compete);
    exp_t e;
    int idx;
    int lat;
    logic [31:0] m;
    check("req_ready_before", 32'(qready[d]), 32'd1);
    idx = int'(addr[14:2]);
    if (addr[1:0] != 2'b00) begin
      e.rdata = 32'd0; e.err = 1'b1;
    end else if (we) begin
      m = model[d][idx];
      for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = wdata[8*i +: 8];
      model[d][idx] = m;
      e.rdata = 32'd0; e.err = 1'b0;
    end else begin
      e.rdata = model[d][idx]; e.err = 1'b0;
    end
    sb.push_back(e);
    rv[d] = 1'b1; ra[d] = addr; rwe[d] = we; rbe[d] = be; rwd[d] = wdata;
    @(posedge clk); #1;
    last_accept = cyc;
    rv[d] = 1'b0;
    lat = 1;
    while (!svalid[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(lat_of(d)));
    if (hold > 0 && compete) begin
      rv[d] = 1'b1; ra[d] = 32'h0; rwe[d] = 1'b1; rbe[d] = 4'hF; rwd[d] = 32'hBAD0BAD0;
    end
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(svalid[d]), 32'd1);
      check("hold_rdata", srdata[d], sb[0].rdata);
      check("hold_req_ready", 32'(qready[d]), 32'd0);
      @(posedge clk); #1;
    end
    rv[d] = 1'b0;
    e = sb.pop_front();
    check("rsp_valid", 32'(svalid[d]), 32'd1);
    check("rsp_rdata", srdata[d], e.rdata);
    check("rsp_err", 32'(serr[d]), 32'(e.err));
    rr[d] = 1'b1;
    @(posedge clk); #1;
    rr[d] = 1'b0;
    check("post_rsp_valid", 32'(svalid[d]), 32'd0);
    check("post_req_ready", 32'(qready[d]), 32'd1);
    $display("[TB] dut%0d %s addr=%h be=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             d, we ? "ST" : "LD", addr, be, wdata, e.rdata, e.err, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int a1;
    rst = 1'b1;
    rv = '0; rwe = '0; rr = '0; ra = '0; rwd = '0; rbe = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset values on every instance
    for (int d = 0; d < 3; d++) begin
      check("rst_req_ready", 32'(qready[d]), 32'd1);
      check("rst_rsp_valid", 32'(svalid[d]), 32'd0);
      check("rst_rdata", srdata[d], 32'd0);
      check("rst_err", 32'(serr[d]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic store then load, LATENCY 2
    txn(1, 1'b1, 32'h8, 4'hF, 32'hDEADBEEF, 0, 1'b0);
    txn(1, 1'b0, 32'h8, 4'h0, 32'h0, 0, 1'b0);

    // Byte enables: expect 0x11BB33DD
    txn(1, 1'b1, 32'h4, 4'hF, 32'h11223344, 0, 1'b0);
    txn(1, 1'b1, 32'h4, 4'b0101, 32'hAABBCCDD, 0, 1'b0);
    txn(1, 1'b0, 32'h4, 4'h0, 32'h0, 0, 1'b0);
    check("be_merge_model", model[1][1], 32'h11BB33DD);

    // Backpressure with a competing request that must be ignored
    txn(1, 1'b1, 32'h0, 4'hF, 32'd5, 0, 1'b0);
    txn(1, 1'b0, 32'h0, 4'h0, 32'h0, 5, 1'b1);
    txn(1, 1'b0, 32'h0, 4'h0, 32'h0, 0, 1'b0);

    // Misaligned store is flagged and leaves memory untouched
    txn(1, 1'b1, 32'h6, 4'hF, 32'h12345678, 0, 1'b0);
    txn(1, 1'b0, 32'h4, 4'h0, 32'h0, 0, 1'b0);

    // Reset in the middle of a LATENCY 4 store
    txn(2, 1'b1, 32'hC, 4'hF, 32'h0C0C0C0C, 0, 1'b0);
    rv[2] = 1'b1; ra[2] = 32'hC; rwe[2] = 1'b1; rbe[2] = 4'hF; rwd[2] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rv[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_rsp_valid", 32'(svalid[2]), 32'd0);
    check("midrst_req_ready", 32'(qready[2]), 32'd1);
    check("midrst_rdata", srdata[2], 32'd0);
    $display("[TB] dut2 reset during pending store to 0000000c");
    txn(2, 1'b0, 32'hC, 4'h0, 32'h0, 0, 1'b0);

    // Address wrap and back-to-back spacing, LATENCY 1
    txn(0, 1'b1, 32'h8000, 4'hF, 32'd7, 0, 1'b0);
    a0 = last_accept;
    txn(0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 1'b0);
    a1 = last_accept;
    check("b2b_spacing", 32'(a1 - a0), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
